// File: rtl/dvi_timing_ctrl.sv
// Programmable DVI timing generator; shadow timing registers commit atomically at frame end.
// Define DVI_TIMING_READBACK_EN to add the registered config read port (cfg_re / cfg_rdata).
module dvi_timing_ctrl #(
    parameter int unsigned CW              = 12,
    parameter bit          ENABLE_AT_RESET = 1'b1,
    parameter int unsigned H_ACT_RST       = 640,
    parameter int unsigned H_FP_RST        = 16,
    parameter int unsigned H_SY_RST        = 96,
    parameter int unsigned H_BP_RST        = 48,
    parameter int unsigned V_ACT_RST       = 480,
    parameter int unsigned V_FP_RST        = 10,
    parameter int unsigned V_SY_RST        = 2,
    parameter int unsigned V_BP_RST        = 33
) (
    input  logic          pixclk,
    input  logic          resetn,
    input  logic          cfg_we,
    input  logic [3:0]    cfg_addr,
    input  logic [CW-1:0] cfg_wdata,
`ifdef DVI_TIMING_READBACK_EN
    input  logic          cfg_re,
    output logic [CW-1:0] cfg_rdata,
`endif
    output logic          cfg_busy,
    output logic [CW-1:0] CounterX,
    output logic [CW-1:0] CounterY,
    output logic          DrawArea,
    output logic          hSync,
    output logic          vSync,
    output logic          line_start,
    output logic          frame_start
);

    localparam int unsigned TW = CW + 2;

    localparam logic [CW-1:0] RstVal [8] = '{
        CW'(H_ACT_RST), CW'(H_FP_RST), CW'(H_SY_RST), CW'(H_BP_RST),
        CW'(V_ACT_RST), CW'(V_FP_RST), CW'(V_SY_RST), CW'(V_BP_RST)
    };

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StDrain = 2'd2
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] shadow_q [8];
    logic [CW-1:0] shadow_d [8];
    logic [CW-1:0] active_q [8];
    logic [CW-1:0] active_d [8];
    logic          enable_q, enable_d;
    logic          hpol_q, hpol_d;
    logic          vpol_q, vpol_d;
    logic          pend_q, pend_d;
    logic [CW-1:0] h_q, h_d, v_q, v_d;

    logic          ctrl_wr, commit_wr, commit;
    logic          h_last, v_last, fe;
    logic [TW-1:0] hs_beg, hs_end, h_tot, vs_beg, vs_end, v_tot;
    logic          draw_d, hs_raw, vs_raw, hsync_d, vsync_d, ls_d, fs_d;

    function automatic logic [TW-1:0] ext(input logic [CW-1:0] x);
        return {2'b00, x};
    endfunction

    assign ctrl_wr   = cfg_we && (cfg_addr == 4'd8);
    assign commit_wr = ctrl_wr && cfg_wdata[3];

    // Totals are wider than the registers so large settings cannot wrap.
    assign hs_beg = ext(active_q[0]) + ext(active_q[1]);
    assign hs_end = hs_beg + ext(active_q[2]);
    assign h_tot  = hs_end + ext(active_q[3]);
    assign vs_beg = ext(active_q[4]) + ext(active_q[5]);
    assign vs_end = vs_beg + ext(active_q[6]);
    assign v_tot  = vs_end + ext(active_q[7]);

    assign h_last = (ext(h_q) == h_tot - TW'(1));
    assign v_last = (ext(v_q) == v_tot - TW'(1));
    assign fe     = h_last && v_last;

    assign commit   = (state_q == StIdle) ? pend_q : (fe && (pend_q || commit_wr));
    assign cfg_busy = pend_q;

    // Config registers; a shadow write in the commit cycle is carried into the active set.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            shadow_d[i] = shadow_q[i];
        end
        if (cfg_we && !cfg_addr[3]) begin
            shadow_d[cfg_addr[2:0]] = (cfg_wdata == '0) ? CW'(1) : cfg_wdata;
        end
        for (int i = 0; i < 8; i++) begin
            active_d[i] = commit ? shadow_d[i] : active_q[i];
        end
        enable_d = ctrl_wr ? cfg_wdata[0] : enable_q;
        hpol_d   = ctrl_wr ? cfg_wdata[1] : hpol_q;
        vpol_d   = ctrl_wr ? cfg_wdata[2] : vpol_q;
        pend_d   = commit ? 1'b0 : (pend_q || commit_wr);
    end

    always_comb begin
        h_d = h_q;
        v_d = v_q;
        if (state_q == StIdle) begin
            h_d = '0;
            v_d = '0;
        end else if (h_last) begin
            h_d = '0;
            v_d = v_last ? '0 : v_q + CW'(1);
        end else begin
            h_d = h_q + CW'(1);
        end
    end

    // State register
    always_ff @(posedge pixclk) begin
        if (!resetn) begin
            state_q <= ENABLE_AT_RESET ? StRun : StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (enable_q) state_d = StRun;
            StRun:   if (!enable_q) state_d = StDrain;
            StDrain: begin
                if (enable_q) begin
                    state_d = StRun;
                end else if (fe) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Output logic, registered below
    always_comb begin
        draw_d = 1'b0;
        hs_raw = 1'b0;
        vs_raw = 1'b0;
        ls_d   = 1'b0;
        fs_d   = 1'b0;
        if (state_q != StIdle) begin
            draw_d = (h_q < active_q[0]) && (v_q < active_q[4]);
            hs_raw = (ext(h_q) >= hs_beg) && (ext(h_q) < hs_end);
            vs_raw = (ext(v_q) >= vs_beg) && (ext(v_q) < vs_end);
            ls_d   = (h_q == '0);
            fs_d   = (h_q == '0) && (v_q == '0);
        end
        hsync_d = hpol_q ? hs_raw : !hs_raw;
        vsync_d = vpol_q ? vs_raw : !vs_raw;
    end

    always_ff @(posedge pixclk) begin
        if (!resetn) begin
            for (int i = 0; i < 8; i++) begin
                shadow_q[i] <= RstVal[i];
                active_q[i] <= RstVal[i];
            end
            enable_q    <= ENABLE_AT_RESET;
            hpol_q      <= 1'b1;
            vpol_q      <= 1'b1;
            pend_q      <= 1'b0;
            h_q         <= '0;
            v_q         <= '0;
            CounterX    <= '0;
            CounterY    <= '0;
            DrawArea    <= 1'b0;
            hSync       <= 1'b0;
            vSync       <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                shadow_q[i] <= shadow_d[i];
                active_q[i] <= active_d[i];
            end
            enable_q    <= enable_d;
            hpol_q      <= hpol_d;
            vpol_q      <= vpol_d;
            pend_q      <= pend_d;
            h_q         <= h_d;
            v_q         <= v_d;
            CounterX    <= h_q;
            CounterY    <= v_q;
            DrawArea    <= draw_d;
            hSync       <= hsync_d;
            vSync       <= vsync_d;
            line_start  <= ls_d;
            frame_start <= fs_d;
        end
    end

`ifdef DVI_TIMING_READBACK_EN
    logic [CW-1:0] rdata_d;

    always_comb begin
        rdata_d = '0;
        if (!cfg_addr[3]) begin
            rdata_d = active_q[cfg_addr[2:0]];
        end else if (cfg_addr == 4'd8) begin
            rdata_d = CW'({pend_q, state_q, vpol_q, hpol_q, enable_q});
        end
    end

    always_ff @(posedge pixclk) begin
        if (!resetn) begin
            cfg_rdata <= '0;
        end else if (cfg_re) begin
            cfg_rdata <= rdata_d;
        end
    end
`endif

endmodule
